cp0_irq_ctrl: RTL



---
 rtl/cp0_pkg.sv | 23 ++
 rtl/irq_pending.sv | 50 +++++
 rtl/cp0_irq_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg
// Shared constants for the coprocessor-0 interrupt controller slice:
// CP0 register numbers and the bit positions of the fields inside SR and
// Cause that both the register file and the read mux rely on.
package cp0_pkg;

  // CP0 register numbers as seen on cp0_addr
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // Field positions inside SR and Cause
  localparam int IM_LSB  = 10;
  localparam int IP_LSB  = 10;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;
  localparam int ID_LSB  = 26;

  // Width of the interrupt channel index (enough for 16 channels)
  localparam int IRQ_ID_W = 4;

endpackage

// File: rtl/irq_pending.sv
// irq_pending
// Per-channel interrupt pending capture. Level channels simply follow the
// registered line; edge channels latch a rising edge and hold it until
// software clears the bit with an mtc0 Cause write of 0.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   hw_int   in   raw interrupt lines (synchronous to clk)
//   clr_en   in   mtc0 Cause write strobe this cycle
//   clr_data in   IP field of the mtc0 Cause write data (0 clears an edge bit)
//   ip       out  registered pending bits
module irq_pending
  import cp0_pkg::*;
#(
  parameter int               N_IRQ     = 6,
  parameter logic [N_IRQ-1:0] EDGE_MASK = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] hw_int,
  input  logic             clr_en,
  input  logic [N_IRQ-1:0] clr_data,
  output logic [N_IRQ-1:0] ip
);

  logic [N_IRQ-1:0] hw_int_q;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] clr;

  // hw_int_q resets to 0, so a line already high when reset releases is
  // seen as a rising edge on the first active cycle.
  assign rise = hw_int & ~hw_int_q;
  assign clr  = {N_IRQ{clr_en}} & ~clr_data;

  // A new edge in the same cycle as a software clear keeps the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      ip       <= '0;
      hw_int_q <= '0;
    end else begin
      hw_int_q <= hw_int;
      for (int i = 0; i < N_IRQ; i++) begin
        if (EDGE_MASK[i]) ip[i] <= rise[i] | (ip[i] & ~clr[i]);
        else              ip[i] <= hw_int[i];
      end
    end
  end

endmodule

// File: rtl/cp0_irq_ctrl.sv
// cp0_irq_ctrl
// Coprocessor-0 block for the five-stage MIPS pipeline: SR, Cause, EPC and
// PRId registers, interrupt pending capture, masking and priority select.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   hw_int     in   raw interrupt lines
//   cp0_we     in   mtc0 write strobe
//   cp0_addr   in   CP0 register number for mfc0/mtc0
//   cp0_wdata  in   mtc0 data
//   cp0_rdata  out  mfc0 data, combinational from cp0_addr
//   exl_set    in   controller takes the interrupt this cycle
//   exl_clr    in   eret executes this cycle
//   epc_pc     in   PC[31:2] saved on exl_set
//   o_epc      out  EPC[31:2] for the eret redirect
//   int_req    out  interrupt request to the controller
//   int_id     out  winning channel index (0 when int_req is low)
module cp0_irq_ctrl
  import cp0_pkg::*;
#(
  parameter int               N_IRQ     = 6,
  parameter logic [N_IRQ-1:0] EDGE_MASK = '0,
  parameter logic [31:0]      PRID      = 32'h0000_4D50
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_IRQ-1:0]    hw_int,
  input  logic                cp0_we,
  input  logic [4:0]          cp0_addr,
  input  logic [31:0]         cp0_wdata,
  output logic [31:0]         cp0_rdata,
  input  logic                exl_set,
  input  logic                exl_clr,
  input  logic [29:0]         epc_pc,
  output logic [29:0]         o_epc,
  output logic                int_req,
  output logic [IRQ_ID_W-1:0] int_id
);

  logic [N_IRQ-1:0]    im;
  logic                exl;
  logic                ie;
  logic [29:0]         epc;
  logic [IRQ_ID_W-1:0] cause_id;
  logic [N_IRQ-1:0]    ip;
  logic [N_IRQ-1:0]    pend;
  logic [IRQ_ID_W-1:0] win_id;

  logic wr_sr;
  logic wr_cause;
  logic wr_epc;

  assign wr_sr    = cp0_we && (cp0_addr == CP0_SR);
  assign wr_cause = cp0_we && (cp0_addr == CP0_CAUSE);
  assign wr_epc   = cp0_we && (cp0_addr == CP0_EPC);

  irq_pending #(
    .N_IRQ     (N_IRQ),
    .EDGE_MASK (EDGE_MASK)
  ) u_pending (
    .clk      (clk),
    .rst      (rst),
    .hw_int   (hw_int),
    .clr_en   (wr_cause),
    .clr_data (cp0_wdata[IP_LSB +: N_IRQ]),
    .ip       (ip)
  );

  // Later assignments override earlier ones: exl_set beats both the
  // mtc0 SR value and exl_clr for EXL, and epc_pc beats an mtc0 EPC write.
  always_ff @(posedge clk) begin
    if (rst) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      epc      <= '0;
      cause_id <= '0;
    end else begin
      if (wr_sr) begin
        im  <= cp0_wdata[IM_LSB +: N_IRQ];
        exl <= cp0_wdata[EXL_BIT];
        ie  <= cp0_wdata[IE_BIT];
      end
      if (wr_epc) epc <= cp0_wdata[31:2];
      if (exl_clr) exl <= 1'b0;
      if (exl_set) begin
        exl      <= 1'b1;
        epc      <= epc_pc;
        cause_id <= int_id;
      end
    end
  end

  assign pend    = ip & im;
  assign int_req = (|pend) & ie & ~exl;

  // Highest set index wins; the loop leaves the last (highest) hit.
  always_comb begin
    win_id = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (pend[i]) win_id = IRQ_ID_W'(i);
    end
  end

  assign int_id = int_req ? win_id : '0;
  assign o_epc  = epc;

  // mfc0 read mux; no bypass of a same-cycle mtc0 to the same register.
  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      CP0_SR: begin
        cp0_rdata[IM_LSB +: N_IRQ] = im;
        cp0_rdata[EXL_BIT]         = exl;
        cp0_rdata[IE_BIT]          = ie;
      end
      CP0_CAUSE: begin
        cp0_rdata[IP_LSB +: N_IRQ]    = ip;
        cp0_rdata[ID_LSB +: IRQ_ID_W] = cause_id;
      end
      CP0_EPC:  cp0_rdata = {epc, 2'b00};
      CP0_PRID: cp0_rdata = PRID;
      default:  cp0_rdata = '0;
    endcase
  end

endmodule
